// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, LOCKED streams one packet from the owner.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Default beat width, matching the fifo data port.
  localparam int DATA_W_DEF = 32;

  // Width needed to index n items; never below 1 bit.
  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] winner,
  output logic          any
);

  // Scan from ptr upward, wrapping; the first set request wins.
  always_comb begin
    int idx;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        winner = GW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one fifo write port among N_REQ sources.
// Handshake: a source beat transfers in a cycle where req_valid[i] & req_ready[i];
// req_ready of the owner follows ~fifo_wrfull combinationally, so no write is ever
// issued while the fifo is full. busy mirrors the FSM state (1 = LOCKED).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16,
  localparam int GRANT_W  = grant_w(N_REQ),
  localparam int BC_W     = grant_w(MAX_BEATS)
) (
  input  logic                      wrclk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      fifo_wrreq,
  input  logic                      fifo_wrfull,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [N_REQ-1:0]          overrun_err
);

  arb_state_t         state;
  arb_state_t         state_next;
  logic [GRANT_W-1:0] rr_ptr;
  logic [BC_W-1:0]    beat_cnt;

  logic [GRANT_W-1:0] pick_winner;
  logic               pick_any;

  logic               owner_valid;
  logic               owner_last;
  logic               accept;
  logic               stall;
  logic               at_limit;
  logic               release_pkt;
  logic [GRANT_W-1:0] next_ptr;
  int                 owner;

  rr_pick #(
    .N  (N_REQ),
    .GW (GRANT_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Owner-side beat qualifiers used by both the FSM and the datapath.
  always_comb begin
    owner       = int'(grant_id);
    owner_valid = req_valid[owner];
    owner_last  = req_last[owner];
    accept      = (state == LOCKED) && owner_valid && !fifo_wrfull;
    stall       = (state == LOCKED) && owner_valid && fifo_wrfull;
    at_limit    = (beat_cnt == BC_W'(MAX_BEATS - 1));
    release_pkt = accept && (owner_last || at_limit);
    next_ptr    = (owner == N_REQ - 1) ? '0 : GRANT_W'(owner + 1);
  end

  // FSM state register.
  always_ff @(posedge wrclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state: grant on any request, release on last beat or beat limit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any)    state_next = LOCKED;
      LOCKED:  if (release_pkt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, rotation pointer and per-packet beat counter.
  always_ff @(posedge wrclk) begin
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        grant_id <= pick_winner;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      // Releasing owner becomes lowest priority at the next arbitration.
      if (release_pkt) rr_ptr <= next_ptr;
    end
  end

  // Status: saturating stall counter and sticky per-source overrun flags.
  always_ff @(posedge wrclk) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      overrun_err <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (accept && !owner_last && at_limit) overrun_err[owner] <= 1'b1;
    end
  end

  // Output muxing: only the owner sees ready, and only while the fifo has room.
  always_comb begin
    req_ready  = '0;
    fifo_wrreq = 1'b0;
    fifo_data  = '0;
    busy       = 1'b0;
    if (state == LOCKED) begin
      busy              = 1'b1;
      req_ready[owner]  = !fifo_wrfull;
      fifo_wrreq        = owner_valid && !fifo_wrfull;
      fifo_data         = req_data[owner*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a per-cycle reference model and write log.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int CW = 16;
  localparam int GW = 2;

  logic              wrclk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     fifo_data;
  logic              fifo_wrreq;
  logic              fifo_wrfull = 1'b0;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic [CW-1:0]     stall_cnt;
  logic [N-1:0]      overrun_err;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BEATS (MB),
    .CNT_W     (CW)
  ) dut (
    .wrclk       (wrclk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_data   (fifo_data),
    .fifo_wrreq  (fifo_wrreq),
    .fifo_wrfull (fifo_wrfull),
    .grant_id    (grant_id),
    .busy        (busy),
    .stall_cnt   (stall_cnt),
    .overrun_err (overrun_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 wrclk = ~wrclk;

  int cyc = 0;
  always @(posedge wrclk) cyc++;

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] mk(input int s, input int b);
    return (DW'(s) << 28) | DW'(b);
  endfunction

  // ---------------- source drivers ----------------
  logic [DW:0] src_q [N][$];
  logic [N-1:0] acc = '0;
  bit flush;

  // Each source pops its head after a handshake and presents the next beat.
  always @(posedge wrclk) begin
    logic [DW:0] h;
    flush = !rst_n;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (flush) src_q[i].delete();
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = h[DW-1:0];
        req_last[i]           = h[DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  end

  task automatic push(input int s, input logic [DW-1:0] d, input logic last);
    src_q[s].push_back({last, d});
  endtask

  // ---------------- reference model + compare ----------------
  int            m_owner = -1;
  int            m_gid   = 0;
  int            m_rr    = 0;
  int            m_beats = 0;
  logic [CW-1:0] m_stall = '0;
  logic [N-1:0]  m_ovr   = '0;

  logic [DW-1:0] wr_log[$];
  int            wr_cyc[$];

  // Compare DUT outputs to the model mid-cycle, then advance the model.
  always @(negedge wrclk) begin
    logic [N-1:0]  e_ready;
    logic          e_wrreq;
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic          rel;
    e_ready = '0;
    e_wrreq = 1'b0;
    e_data  = '0;
    e_busy  = 1'b0;
    if (m_owner >= 0) begin
      e_busy           = 1'b1;
      e_ready[m_owner] = !fifo_wrfull;
      e_wrreq          = req_valid[m_owner] && !fifo_wrfull;
      e_data           = req_data[m_owner*DW +: DW];
    end
    check("req_ready",   64'(req_ready),   64'(e_ready));
    check("fifo_wrreq",  64'(fifo_wrreq),  64'(e_wrreq));
    check("fifo_data",   64'(fifo_data),   64'(e_data));
    check("busy",        64'(busy),        64'(e_busy));
    check("grant_id",    64'(grant_id),    64'(m_gid));
    check("stall_cnt",   64'(stall_cnt),   64'(m_stall));
    check("overrun_err", 64'(overrun_err), 64'(m_ovr));

    acc = req_valid & req_ready;
    if (fifo_wrreq) begin
      wr_log.push_back(fifo_data);
      wr_cyc.push_back(cyc);
    end

    if (!rst_n) begin
      m_owner = -1; m_gid = 0; m_rr = 0; m_beats = 0; m_stall = '0; m_ovr = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req_valid[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
      end
      if (m_owner >= 0) begin
        m_gid   = m_owner;
        m_beats = 0;
      end
    end else begin
      rel = 1'b0;
      if (req_valid[m_owner] && fifo_wrfull && m_stall != '1) m_stall = m_stall + 1'b1;
      if (e_wrreq) begin
        m_beats++;
        if (req_last[m_owner]) rel = 1'b1;
        else if (m_beats == MB) begin
          m_ovr[m_owner] = 1'b1;
          rel = 1'b1;
        end
      end
      if (rel) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic do_reset();
    @(posedge wrclk); #2 rst_n = 1'b0;
    @(posedge wrclk); #2 rst_n = 1'b1;
    wr_log.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (wr_log.size() < n && c < budget) begin
      @(posedge wrclk);
      c++;
    end
    #2;
    check(name, 64'(wr_log.size()), 64'(n));
  endtask

  task automatic clear_log();
    repeat (3) @(posedge wrclk);
    #2;
    wr_log.delete();
    wr_cyc.delete();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int push_cyc;
    logic [DW-1:0] w;

    // Reset state: all outputs zero.
    @(negedge wrclk);
    check("rst_ready",   64'(req_ready),   64'h0);
    check("rst_wrreq",   64'(fifo_wrreq),  64'h0);
    check("rst_data",    64'(fifo_data),   64'h0);
    check("rst_busy",    64'(busy),        64'h0);
    check("rst_grant",   64'(grant_id),    64'h0);
    check("rst_stall",   64'(stall_cnt),   64'h0);
    check("rst_overrun", 64'(overrun_err), 64'h0);
    @(posedge wrclk); #2 rst_n = 1'b1;

    // Src1 three-beat packet: one grant cycle, then three consecutive writes.
    push_cyc = cyc;
    push(1, mk(1, 'hA1), 1'b0);
    push(1, mk(1, 'hA2), 1'b0);
    push(1, mk(1, 'hA3), 1'b1);
    wait_log(3, 30, "t1_count");
    check("t1_beat0", 64'(wr_log[0]), 64'h1000_00A1);
    check("t1_beat1", 64'(wr_log[1]), 64'h1000_00A2);
    check("t1_beat2", 64'(wr_log[2]), 64'h1000_00A3);
    check("t1_latency", 64'(wr_cyc[0] - push_cyc), 64'd2);
    check("t1_gap01", 64'(wr_cyc[1] - wr_cyc[0]), 64'd1);
    check("t1_gap12", 64'(wr_cyc[2] - wr_cyc[1]), 64'd1);

    // Src0 and src2 two-beat packets from rr_ptr=0.
    do_reset();
    push(0, mk(0, 1), 1'b0);
    push(0, mk(0, 2), 1'b1);
    push(2, mk(2, 1), 1'b0);
    push(2, mk(2, 2), 1'b1);
    wait_log(4, 30, "t2_count");
    check("t2_beat0", 64'(wr_log[0]), 64'h0000_0001);
    check("t2_beat1", 64'(wr_log[1]), 64'h0000_0002);
    check("t2_beat2", 64'(wr_log[2]), 64'h2000_0001);
    check("t2_beat3", 64'(wr_log[3]), 64'h2000_0002);
    check("t2_gap01", 64'(wr_cyc[1] - wr_cyc[0]), 64'd1);
    check("t2_gap12", 64'(wr_cyc[2] - wr_cyc[1]), 64'd2);
    check("t2_gap23", 64'(wr_cyc[3] - wr_cyc[2]), 64'd1);

    // Src3 (next in rotation) with wrfull held for 5 cycles mid-packet.
    clear_log();
    for (int b = 1; b <= 4; b++) push(3, mk(3, b), b == 4);
    wait_log(2, 30, "t3_first2");
    fifo_wrfull = 1'b1;
    repeat (5) @(posedge wrclk);
    #2 fifo_wrfull = 1'b0;
    wait_log(4, 30, "t3_count");
    check("t3_stall_cnt", 64'(stall_cnt), 64'd5);
    check("t3_beat2", 64'(wr_log[2]), 64'h3000_0003);
    check("t3_beat3", 64'(wr_log[3]), 64'h3000_0004);
    check("t3_full_gap", 64'(wr_cyc[2] - wr_cyc[1]), 64'd6);

    // All sources busy with 1-beat packets: strict rotation 0,1,2,3,0,...
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) push(s, mk(s, 16 + r), 1'b1);
    wait_log(8, 60, "t4_count");
    for (int i = 0; i < 8; i++) begin
      w = wr_log[i];
      check("t4_order", 64'(w[31:28]), 64'(i % N));
    end

    // Src0 six beats with MAX_BEATS=4: forced release after beat 4.
    clear_log();
    for (int b = 1; b <= 6; b++) push(0, mk(0, 'h40 + b), b == 6);
    wait_log(6, 40, "t5_count");
    check("t5_overrun", 64'(overrun_err), 64'b0001);
    check("t5_beat4", 64'(wr_log[4]), 64'h0000_0045);
    check("t5_beat5", 64'(wr_log[5]), 64'h0000_0046);
    check("t5_gap23", 64'(wr_cyc[3] - wr_cyc[2]), 64'd1);
    check("t5_regrant_gap", 64'(wr_cyc[4] - wr_cyc[3]), 64'd2);

    // Reset asserted during beat 2 of a 4-beat packet.
    clear_log();
    for (int b = 1; b <= 4; b++) push(1, mk(1, 'h50 + b), b == 4);
    wait_log(1, 30, "t6_first");
    rst_n = 1'b0;
    @(posedge wrclk); #2 rst_n = 1'b1;
    @(negedge wrclk);
    check("t6_wrreq",   64'(fifo_wrreq),  64'h0);
    check("t6_busy",    64'(busy),        64'h0);
    check("t6_stall",   64'(stall_cnt),   64'h0);
    check("t6_overrun", 64'(overrun_err), 64'h0);
    repeat (6) @(posedge wrclk);
    #2;
    check("t6_no_more_writes", 64'(wr_log.size()), 64'd2);
    check("t6_beat1", 64'(wr_log[1]), 64'h1000_0052);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
